// File: rtl/mem_lsu_if.sv
// Data-side bus between the load/store unit and the uncached AXI bridge.
// The master issues one request and holds ready while it waits for the single response.
interface data_bus;
  logic        en;
  logic        write;
  logic [63:0] addr;
  logic [1:0]  size;
  logic [63:0] wdata;
  logic        ready;
  logic        valid;
  logic [63:0] rdata;
  logic        acc_err;

  modport master (
    output en, write, addr, size, wdata, ready,
    input  valid, rdata, acc_err
  );

  modport slave (
    input  en, write, addr, size, wdata, ready,
    output valid, rdata, acc_err
  );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: alignment check, one data_bus request, load extension, faults.
// Optional LR/SC reservation support is built when LSU_LRSC_EN is defined.
module mem_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_load,
  input  logic        mem_store,
  input  logic [2:0]  mem_funct3,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
`ifdef LSU_LRSC_EN
  input  logic        mem_lr,
  input  logic        mem_sc,
`endif
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [63:0] rdata,
  output logic        exc_ld_misalign,
  output logic        exc_st_misalign,
  output logic        exc_ld_access,
  output logic        exc_st_access,
  data_bus.master     dbus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        en_q, en_d;
  logic        ready_q, ready_d;
  logic        kill_q, kill_d;
  logic        done_q, done_d;
  logic [63:0] rdata_q, rdata_d;
  logic        ld_mis_q, ld_mis_d, st_mis_q, st_mis_d;
  logic        ld_acc_q, ld_acc_d, st_acc_q, st_acc_d;
`ifdef LSU_LRSC_EN
  logic        resv_valid_q, resv_valid_d;
  logic [63:0] resv_addr_q, resv_addr_d;
  logic        lr_q, lr_d;
`endif

  logic        accept;
  logic        misaligned;
  logic        killed;
  logic [63:0] shifted;
  logic [63:0] ld_ext;

  assign accept = mem_valid & (mem_load | mem_store) & ~flush;
  assign killed = kill_q | flush;

  always_comb begin
    misaligned = 1'b0;
    case (mem_funct3[1:0])
      2'd0: misaligned = 1'b0;
      2'd1: misaligned = mem_addr[0];
      2'd2: misaligned = |mem_addr[1:0];
      default: misaligned = |mem_addr[2:0];
    endcase
  end

  // Response lanes are byte-addressed within the 64-bit beat.
  always_comb begin
    shifted = dbus.rdata >> {addr_q[2:0], 3'b000};
    ld_ext  = shifted;
    case (funct3_q[1:0])
      2'd0: ld_ext = funct3_q[2] ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: ld_ext = funct3_q[2] ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: ld_ext = funct3_q[2] ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    en_d     = 1'b0;
    ready_d  = 1'b0;
    kill_d   = kill_q;
    done_d   = 1'b0;
    rdata_d  = 64'd0;
    ld_mis_d = 1'b0;
    st_mis_d = 1'b0;
    ld_acc_d = 1'b0;
    st_acc_d = 1'b0;
    stall    = 1'b0;
`ifdef LSU_LRSC_EN
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    lr_d         = lr_q;
`endif
    case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (accept) begin
          stall    = 1'b1;
          write_d  = mem_store;
          funct3_d = mem_funct3;
          addr_d   = mem_addr;
          wdata_d  = mem_wdata << {mem_addr[2:0], 3'b000};
`ifdef LSU_LRSC_EN
          lr_d = mem_lr & mem_load;
          if (mem_sc) resv_valid_d = 1'b0;
`endif
          if (misaligned) begin
            state_d  = StDone;
            done_d   = 1'b1;
            ld_mis_d = mem_load;
            st_mis_d = mem_store;
`ifdef LSU_LRSC_EN
          end else if (mem_sc && !(resv_valid_q && resv_addr_q == mem_addr)) begin
            // Failed SC completes without touching the bus.
            state_d = StDone;
            done_d  = 1'b1;
            rdata_d = 64'd1;
`endif
          end else begin
            state_d = StReq;
            en_d    = 1'b1;
          end
        end
      end
      StReq: begin
        stall   = 1'b1;
        ready_d = 1'b1;
        state_d = StWait;
        if (flush) kill_d = 1'b1;
      end
      StWait: begin
        stall = 1'b1;
        if (flush) kill_d = 1'b1;
        if (dbus.valid) begin
          state_d = StDone;
          if (!killed) begin
            done_d   = 1'b1;
            ld_acc_d = ~write_q & dbus.acc_err;
            st_acc_d = write_q & dbus.acc_err;
            rdata_d  = (write_q || dbus.acc_err) ? 64'd0 : ld_ext;
`ifdef LSU_LRSC_EN
            if (lr_q && !dbus.acc_err) begin
              resv_valid_d = 1'b1;
              resv_addr_d  = addr_q;
            end
`endif
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        kill_d  = 1'b0;
      end
    endcase
`ifdef LSU_LRSC_EN
    if (flush) resv_valid_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      en_q     <= 1'b0;
      ready_q  <= 1'b0;
      kill_q   <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 64'd0;
      ld_mis_q <= 1'b0;
      st_mis_q <= 1'b0;
      ld_acc_q <= 1'b0;
      st_acc_q <= 1'b0;
`ifdef LSU_LRSC_EN
      resv_valid_q <= 1'b0;
      resv_addr_q  <= 64'd0;
      lr_q         <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      en_q     <= en_d;
      ready_q  <= ready_d;
      kill_q   <= kill_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      ld_mis_q <= ld_mis_d;
      st_mis_q <= st_mis_d;
      ld_acc_q <= ld_acc_d;
      st_acc_q <= st_acc_d;
`ifdef LSU_LRSC_EN
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
      lr_q         <= lr_d;
`endif
    end
  end

  // A flush arriving in the DONE cycle itself still withdraws the result strobe.
  assign done            = done_q & ~flush;
  assign rdata           = rdata_q;
  assign exc_ld_misalign = ld_mis_q;
  assign exc_st_misalign = st_mis_q;
  assign exc_ld_access   = ld_acc_q;
  assign exc_st_access   = st_acc_q;

  assign dbus.en    = en_q;
  assign dbus.write = write_q;
  assign dbus.addr  = addr_q;
  assign dbus.size  = funct3_q[1:0];
  assign dbus.wdata = wdata_q;
  assign dbus.ready = ready_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a small in-bench bus slave answers each request after a set delay.
// Build with LSU_LRSC_EN defined to also exercise the LR/SC path.
module tb_mem_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        mem_valid, mem_load, mem_store, flush;
  logic [2:0]  mem_funct3;
  logic [63:0] mem_addr, mem_wdata;
`ifdef LSU_LRSC_EN
  logic        mem_lr, mem_sc;
`endif
  logic        stall, done;
  logic [63:0] rdata;
  logic        exc_ld_misalign, exc_st_misalign, exc_ld_access, exc_st_access;

  data_bus bus ();

  mem_lsu dut (
    .clock           (clock),
    .reset           (reset),
    .mem_valid       (mem_valid),
    .mem_load        (mem_load),
    .mem_store       (mem_store),
    .mem_funct3      (mem_funct3),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
`ifdef LSU_LRSC_EN
    .mem_lr          (mem_lr),
    .mem_sc          (mem_sc),
`endif
    .flush           (flush),
    .stall           (stall),
    .done            (done),
    .rdata           (rdata),
    .exc_ld_misalign (exc_ld_misalign),
    .exc_st_misalign (exc_st_misalign),
    .exc_ld_access   (exc_ld_access),
    .exc_st_access   (exc_st_access),
    .dbus            (bus)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  // Observations from the most recent run_op, indexed by cycle after the accept edge.
  int          obs_en_cnt, obs_done_cyc, obs_done_cnt, obs_stall_low;
  logic        obs_accept_stall, obs_write, obs_ready_at_valid;
  logic [1:0]  obs_size;
  logic [63:0] obs_addr, obs_wdata, obs_rdata;
  logic [3:0]  obs_exc;

  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input int w,
                        input logic [63:0] resp, input logic err, input int flush_at);
    int en_cyc;
    en_cyc = -1;
    obs_en_cnt = 0; obs_done_cyc = 0; obs_done_cnt = 0; obs_stall_low = 0;
    obs_write = 1'b0; obs_size = 2'd0; obs_addr = '0; obs_wdata = '0;
    obs_rdata = '0; obs_exc = '0; obs_ready_at_valid = 1'b0;
    @(posedge clock); #1;
    mem_valid = 1'b1; mem_load = ld; mem_store = st; mem_funct3 = f3;
    mem_addr = a; mem_wdata = wd;
    @(negedge clock);
    obs_accept_stall = stall;
    @(posedge clock); #1;
    mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      flush       = (c == flush_at);
      bus.valid   = (en_cyc >= 0) && (c == en_cyc + 1 + w);
      bus.rdata   = bus.valid ? resp : 64'hA5A5_A5A5_A5A5_A5A5;
      bus.acc_err = bus.valid ? err : 1'b1;
      @(negedge clock);
      if (bus.en) begin
        obs_en_cnt++;
        if (en_cyc < 0) en_cyc = c;
        obs_write = bus.write; obs_size = bus.size;
        obs_addr = bus.addr; obs_wdata = bus.wdata;
      end
      if (bus.valid) obs_ready_at_valid = bus.ready;
      if (!stall && obs_stall_low == 0) obs_stall_low = c;
      if (done) begin
        obs_done_cnt++;
        if (obs_done_cyc == 0) begin
          obs_done_cyc = c;
          obs_rdata = rdata;
          obs_exc = {exc_ld_misalign, exc_st_misalign, exc_ld_access, exc_st_access};
        end
      end
      @(posedge clock); #1;
    end
    flush = 1'b0; bus.valid = 1'b0; bus.acc_err = 1'b0; bus.rdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    total++; if ({bus.en, bus.write, bus.ready} !== 3'b000)
      $display("FAIL reset_bus_ctrl got %b want 000", {bus.en, bus.write, bus.ready}); else passed++;
    total++; if ({bus.addr, bus.wdata, bus.size} !== 130'd0)
      $display("FAIL reset_bus_fields got %h/%h/%0d want 0", bus.addr, bus.wdata, bus.size); else passed++;
    total++; if ({done, stall, rdata} !== 66'd0)
      $display("FAIL reset_outputs got done=%b stall=%b rdata=%h want 0", done, stall, rdata); else passed++;
    total++; if ({exc_ld_misalign, exc_st_misalign, exc_ld_access, exc_st_access} !== 4'b0)
      $display("FAIL reset_exc got %b want 0000",
               {exc_ld_misalign, exc_st_misalign, exc_ld_access, exc_st_access}); else passed++;
  endtask

  task automatic test_ld();
    run_op(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'd0, 2, 64'h1122_3344_5566_7788, 1'b0, 0);
    total++; if (obs_accept_stall !== 1'b1)
      $display("FAIL ld_accept_stall got %b want 1", obs_accept_stall); else passed++;
    total++; if (obs_done_cyc !== 5) $display("FAIL ld_latency got %0d want 5", obs_done_cyc); else passed++;
    total++; if (obs_rdata !== 64'h1122_3344_5566_7788)
      $display("FAIL ld_rdata got %h want 1122334455667788", obs_rdata); else passed++;
    total++; if (obs_exc !== 4'b0) $display("FAIL ld_exc got %b want 0000", obs_exc); else passed++;
    total++; if ({obs_en_cnt, obs_write, obs_size, obs_addr} !== {32'd1, 1'b0, 2'd3, 64'h8000_0010})
      $display("FAIL ld_bus got en=%0d w=%b sz=%0d a=%h want 1/0/3/80000010",
               obs_en_cnt, obs_write, obs_size, obs_addr); else passed++;
    total++; if (obs_done_cnt !== 1) $display("FAIL ld_done_pulses got %0d want 1", obs_done_cnt); else passed++;
  endtask

  task automatic test_ext();
    run_op(1'b1, 1'b0, 3'b000, 64'h8000_0013, 64'd0, 0, 64'h0000_0000_8000_0000, 1'b0, 0);
    total++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_FF80)
      $display("FAIL lb_rdata got %h want ffffffffffffff80", obs_rdata); else passed++;
    total++; if (obs_done_cyc !== 3) $display("FAIL lb_latency got %0d want 3", obs_done_cyc); else passed++;
    run_op(1'b1, 1'b0, 3'b100, 64'h8000_0013, 64'd0, 0, 64'h0000_0000_8000_0000, 1'b0, 0);
    total++; if (obs_rdata !== 64'h80) $display("FAIL lbu_rdata got %h want 80", obs_rdata); else passed++;
    run_op(1'b1, 1'b0, 3'b001, 64'h8000_0006, 64'd0, 1, 64'h8001_0000_0000_0000, 1'b0, 0);
    total++; if (obs_rdata !== 64'hFFFF_FFFF_FFFF_8001)
      $display("FAIL lh_rdata got %h want ffffffffffff8001", obs_rdata); else passed++;
    run_op(1'b1, 1'b0, 3'b101, 64'h8000_0006, 64'd0, 1, 64'h8001_0000_0000_0000, 1'b0, 0);
    total++; if (obs_rdata !== 64'h8001) $display("FAIL lhu_rdata got %h want 8001", obs_rdata); else passed++;
    run_op(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'd0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0, 0);
    total++; if (obs_rdata !== 64'hFFFF_FFFF_DEAD_BEEF)
      $display("FAIL lw_rdata got %h want ffffffffdeadbeef", obs_rdata); else passed++;
    total++; if (obs_size !== 2'd2) $display("FAIL lw_size got %0d want 2", obs_size); else passed++;
    run_op(1'b1, 1'b0, 3'b110, 64'h8000_0004, 64'd0, 0, 64'hDEAD_BEEF_0000_0000, 1'b0, 0);
    total++; if (obs_rdata !== 64'h0000_0000_DEAD_BEEF)
      $display("FAIL lwu_rdata got %h want deadbeef", obs_rdata); else passed++;
    run_op(1'b1, 1'b0, 3'b111, 64'h8000_0008, 64'd0, 0, 64'hF000_0000_0000_0001, 1'b0, 0);
    total++; if ({obs_size, obs_rdata} !== {2'd3, 64'hF000_0000_0000_0001})
      $display("FAIL ld111 got sz=%0d rdata=%h want 3/f000000000000001", obs_size, obs_rdata); else passed++;
  endtask

  task automatic test_store();
    run_op(1'b0, 1'b1, 3'b001, 64'h8000_0006, 64'hBEEF, 0, 64'd0, 1'b0, 0);
    total++; if ({obs_write, obs_size} !== 3'b1_01)
      $display("FAIL sh_ctrl got w=%b sz=%0d want 1/1", obs_write, obs_size); else passed++;
    total++; if (obs_wdata !== 64'hBEEF_0000_0000_0000)
      $display("FAIL sh_wdata got %h want beef000000000000", obs_wdata); else passed++;
    total++; if (obs_en_cnt !== 1) $display("FAIL sh_en_cycles got %0d want 1", obs_en_cnt); else passed++;
    total++; if ({obs_done_cyc, obs_exc} !== {32'd3, 4'b0})
      $display("FAIL sh_done got cyc=%0d exc=%b want 3/0000", obs_done_cyc, obs_exc); else passed++;
    run_op(1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 1, 64'd0, 1'b1, 0);
    total++; if (obs_exc !== 4'b0001) $display("FAIL sd_acc_err got %b want 0001", obs_exc); else passed++;
    total++; if (obs_wdata !== 64'h0123_4567_89AB_CDEF)
      $display("FAIL sd_wdata got %h want 0123456789abcdef", obs_wdata); else passed++;
  endtask

  task automatic test_faults();
    run_op(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, 0, 64'd0, 1'b0, 0);
    total++; if (obs_en_cnt !== 0) $display("FAIL lw_mis_en got %0d want 0", obs_en_cnt); else passed++;
    total++; if (obs_done_cyc !== 1) $display("FAIL lw_mis_latency got %0d want 1", obs_done_cyc); else passed++;
    total++; if (obs_exc !== 4'b1000) $display("FAIL lw_mis_exc got %b want 1000", obs_exc); else passed++;
    total++; if (obs_stall_low !== 1)
      $display("FAIL lw_mis_stall got first-low %0d want 1", obs_stall_low); else passed++;
    run_op(1'b0, 1'b1, 3'b011, 64'h8000_0004, 64'd5, 0, 64'd0, 1'b0, 0);
    total++; if ({obs_en_cnt, obs_exc} !== {32'd0, 4'b0100})
      $display("FAIL sd_mis got en=%0d exc=%b want 0/0100", obs_en_cnt, obs_exc); else passed++;
    run_op(1'b1, 1'b0, 3'b011, 64'h8000_0018, 64'd0, 0, 64'h1234, 1'b1, 0);
    total++; if ({obs_exc, obs_rdata} !== {4'b0010, 64'd0})
      $display("FAIL ld_acc got exc=%b rdata=%h want 0010/0", obs_exc, obs_rdata); else passed++;
  endtask

  task automatic test_flush();
    run_op(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'd0, 3, 64'h77, 1'b0, 3);
    total++; if (obs_done_cnt !== 0) $display("FAIL flush_wait_done got %0d want 0", obs_done_cnt); else passed++;
    total++; if (obs_ready_at_valid !== 1'b1)
      $display("FAIL flush_wait_ready got %b want 1", obs_ready_at_valid); else passed++;
    total++; if (obs_stall_low !== 6)
      $display("FAIL flush_wait_stall got first-low %0d want 6", obs_stall_low); else passed++;
    run_op(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'd0, 2, 64'h55, 1'b0, 0);
    total++; if ({obs_done_cyc, obs_rdata} !== {32'd5, 64'h55})
      $display("FAIL after_flush got cyc=%0d rdata=%h want 5/55", obs_done_cyc, obs_rdata); else passed++;
    run_op(1'b1, 1'b0, 3'b011, 64'h8000_0020, 64'd0, 2, 64'h55, 1'b0, 5);
    total++; if (obs_done_cnt !== 0) $display("FAIL flush_done got %0d want 0", obs_done_cnt); else passed++;
  endtask

`ifdef LSU_LRSC_EN
  task automatic test_lrsc();
    mem_lr = 1'b1;
    run_op(1'b1, 1'b0, 3'b011, 64'h8000_0040, 64'd0, 0, 64'h9, 1'b0, 0);
    mem_lr = 1'b0; mem_sc = 1'b1;
    run_op(1'b0, 1'b1, 3'b011, 64'h8000_0040, 64'hAB, 0, 64'd0, 1'b0, 0);
    total++; if ({obs_en_cnt, obs_write, obs_rdata} !== {32'd1, 1'b1, 64'd0})
      $display("FAIL sc_ok got en=%0d w=%b rdata=%h want 1/1/0", obs_en_cnt, obs_write, obs_rdata); else passed++;
    run_op(1'b0, 1'b1, 3'b011, 64'h8000_0040, 64'hAB, 0, 64'd0, 1'b0, 0);
    total++; if ({obs_en_cnt, obs_done_cyc, obs_rdata} !== {32'd0, 32'd1, 64'd1})
      $display("FAIL sc_fail got en=%0d cyc=%0d rdata=%h want 0/1/1",
               obs_en_cnt, obs_done_cyc, obs_rdata); else passed++;
    mem_sc = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_load = 1'b0; mem_store = 1'b0; flush = 1'b0;
    mem_funct3 = '0; mem_addr = '0; mem_wdata = '0;
    bus.valid = 1'b0; bus.rdata = '0; bus.acc_err = 1'b0;
`ifdef LSU_LRSC_EN
    mem_lr = 1'b0; mem_sc = 1'b0;
`endif
    test_reset();
    test_ld();
    test_ext();
    test_store();
    test_faults();
    test_flush();
`ifdef LSU_LRSC_EN
    test_lrsc();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
